// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the spi_arbiter slice.
// Contents: arbiter state enum, chip-select index constants, select width.
// No logic; imported by spi_arbiter, spi_rr_pick and the bench.
package spi_arb_pkg;

  // Arbiter FSM states, in the order a transaction normally walks them.
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ACTIVE,
    BUSY,
    RELEASE
  } arb_state_t;

  // Width of the per-requester device select.
  localparam int CS_SEL_W = 2;

  // Chip-select indices on spi_cs_n.
  localparam int CS_FLASH = 0;
  localparam int CS_RAM   = 1;
  localparam int CS_EXT   = 2;

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: two-way round-robin picker for bus ownership.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: lock0/lock1 requests, last_owner (who held the bus last),
//        valid (someone is asking), winner (0 = requester 0, 1 = requester 1).
module spi_rr_pick
  import spi_arb_pkg::*;
(
  input  logic lock0,
  input  logic lock1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = lock0 | lock1;
    winner = 1'b0;
    // On a tie the requester that did not own the bus last goes next;
    // a lone requester always wins.
    if (lock0 && lock1) begin
      winner = ~last_owner;
    end else if (lock1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_core byte engine between mem_ctrl (req0) and
//   the register-space SPI peripheral (req1), one transaction per grant.
// Latency: lock->grant/CS 2 cycles, start->spi_txn_start 1, done->txn_done 1.
// Backpressure: txn_start from the owner is only honoured in ACTIVE; starts
//   from the non-owner or while a byte is in flight are dropped.
// Ports: reqN_* requester side (lock, cs_sel, data_tx, txn_start, grant,
//   data_rx, txn_done), spi_* byte engine side, spi_cs_n active-low selects.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CS   = 3,
  parameter int IDLE_GAP = 2   // must be >= 1
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                req0_lock,
  input  logic [CS_SEL_W-1:0] req0_cs_sel,
  input  logic [7:0]          req0_data_tx,
  input  logic                req0_txn_start,
  output logic                req0_grant,
  output logic [7:0]          req0_data_rx,
  output logic                req0_txn_done,

  input  logic                req1_lock,
  input  logic [CS_SEL_W-1:0] req1_cs_sel,
  input  logic [7:0]          req1_data_tx,
  input  logic                req1_txn_start,
  output logic                req1_grant,
  output logic [7:0]          req1_data_rx,
  output logic                req1_txn_done,

  output logic [7:0]          spi_data_tx,
  output logic                spi_txn_start,
  input  logic [7:0]          spi_data_rx,
  input  logic                spi_txn_done,
  output logic [NUM_CS-1:0]   spi_cs_n
);

  // Gap counter only needs to reach IDLE_GAP-1.
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  arb_state_t         state;
  logic               owner;
  logic               last_owner;
  logic [GAP_W-1:0]   gap_cnt;

  logic               pick_valid;
  logic               pick_winner;

  logic               own_lock;
  logic               own_start;
  logic [7:0]         own_data_tx;
  logic [CS_SEL_W-1:0] own_cs_sel;
  logic [NUM_CS-1:0]  cs_dec;

  spi_rr_pick u_pick (
    .lock0      (req0_lock),
    .lock1      (req1_lock),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Everything the FSM needs from the current owner, muxed once.
  always_comb begin
    own_lock    = owner ? req1_lock      : req0_lock;
    own_start   = owner ? req1_txn_start : req0_txn_start;
    own_data_tx = owner ? req1_data_tx   : req0_data_tx;
    own_cs_sel  = owner ? req1_cs_sel    : req0_cs_sel;
  end

  // One-cold decode of the owner's select. A select past the last line
  // leaves every CS high; the transaction still runs, it just addresses
  // nothing.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (own_cs_sel == CS_SEL_W'(i)) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_owner    <= 1'b1;
      gap_cnt       <= '0;
      spi_cs_n      <= '1;
      req0_grant    <= 1'b0;
      req1_grant    <= 1'b0;
      spi_txn_start <= 1'b0;
      spi_data_tx   <= 8'h00;
      req0_data_rx  <= 8'h00;
      req1_data_rx  <= 8'h00;
      req0_txn_done <= 1'b0;
      req1_txn_done <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      spi_txn_start <= 1'b0;
      req0_txn_done <= 1'b0;
      req1_txn_done <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick_winner;
            last_owner <= pick_winner;
            state      <= GRANT;
          end
        end

        GRANT: begin
          // cs_sel is captured here into spi_cs_n and never re-read while
          // owning, so later select changes cannot move the chip select.
          spi_cs_n   <= cs_dec;
          req0_grant <= ~owner;
          req1_grant <= owner;
          state      <= ACTIVE;
        end

        ACTIVE: begin
          // A lock drop wins over a simultaneous start.
          if (!own_lock) begin
            state <= RELEASE;
          end else if (own_start) begin
            spi_data_tx   <= own_data_tx;
            spi_txn_start <= 1'b1;
            state         <= BUSY;
          end
        end

        BUSY: begin
          // The byte always completes, even if the lock has gone away;
          // the lock only decides where we go afterwards.
          if (spi_txn_done) begin
            if (owner) begin
              req1_data_rx  <= spi_data_rx;
              req1_txn_done <= 1'b1;
            end else begin
              req0_data_rx  <= spi_data_rx;
              req0_txn_done <= 1'b1;
            end
            state <= own_lock ? ACTIVE : RELEASE;
          end
        end

        RELEASE: begin
          spi_cs_n   <= '1;
          req0_grant <= 1'b0;
          req1_grant <= 1'b0;
          if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: self-checking bench for spi_arbiter with a small spi_core
// model and a scoreboard of expected bytes per transaction.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int NUM_CS   = 3;
  localparam int IDLE_GAP = 2;
  localparam int CORE_LAT = 3;

  logic                clk;
  logic                rst_n;
  logic                req0_lock, req1_lock;
  logic [CS_SEL_W-1:0] req0_cs_sel, req1_cs_sel;
  logic [7:0]          req0_data_tx, req1_data_tx;
  logic                req0_txn_start, req1_txn_start;
  logic                req0_grant, req1_grant;
  logic [7:0]          req0_data_rx, req1_data_rx;
  logic                req0_txn_done, req1_txn_done;
  logic [7:0]          spi_data_tx;
  logic                spi_txn_start;
  logic [7:0]          spi_data_rx;
  logic                spi_txn_done;
  logic [NUM_CS-1:0]   spi_cs_n;

  spi_arbiter #(.NUM_CS(NUM_CS), .IDLE_GAP(IDLE_GAP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_lock      (req0_lock),
    .req0_cs_sel    (req0_cs_sel),
    .req0_data_tx   (req0_data_tx),
    .req0_txn_start (req0_txn_start),
    .req0_grant     (req0_grant),
    .req0_data_rx   (req0_data_rx),
    .req0_txn_done  (req0_txn_done),
    .req1_lock      (req1_lock),
    .req1_cs_sel    (req1_cs_sel),
    .req1_data_tx   (req1_data_tx),
    .req1_txn_start (req1_txn_start),
    .req1_grant     (req1_grant),
    .req1_data_rx   (req1_data_rx),
    .req1_txn_done  (req1_txn_done),
    .spi_data_tx    (spi_data_tx),
    .spi_txn_start  (spi_txn_start),
    .spi_data_rx    (spi_data_rx),
    .spi_txn_done   (spi_txn_done),
    .spi_cs_n       (spi_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       who;
    logic [7:0] tx;
    logic [7:0] rx;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  sb_t  new_e;
  int   total = 0;
  int   bad = 0;
  int   nstart = 0;
  int   exp_starts = 0;
  int   core_cnt = 0;
  logic [7:0] core_rx = 8'h00;
  logic [7:0] core_tx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge, well clear of the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive_start(input logic who, input logic s, input logic [7:0] d);
    if (who) begin
      req1_txn_start = s;
      req1_data_tx   = d;
    end else begin
      req0_txn_start = s;
      req0_data_tx   = d;
    end
  endtask

  task automatic expect_byte(input logic who, input logic [7:0] tx, input logic [7:0] rx);
    new_e.who = who;
    new_e.tx  = tx;
    new_e.rx  = rx;
    sb.push_back(new_e);
    exp_starts++;
    core_rx = rx;
  endtask

  // One byte from the current owner; dbl adds a second start while BUSY.
  task automatic send(input logic who, input logic [7:0] tx, input logic [7:0] rx, input bit dbl);
    bit ok;
    expect_byte(who, tx, rx);
    drive_start(who, 1'b1, tx);
    tick();
    chk("start_hi", spi_txn_start, 1);
    chk("tx_lat", spi_data_tx, tx);
    if (dbl) drive_start(who, 1'b1, ~tx);
    else     drive_start(who, 1'b0, tx);
    tick();
    drive_start(who, 1'b0, tx);
    chk("start_1cyc", spi_txn_start, 0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("sb_drain", ok, 1);
  endtask

  task automatic wait_grant(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req0_grant || req1_grant) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  // spi_core model plus output monitor, all on the falling edge.
  initial begin
    spi_txn_done = 1'b0;
    spi_data_rx  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        core_cnt     = 0;
        spi_txn_done = 1'b0;
      end else begin
        // A done driven last falling edge must show up as txn_done now.
        if (spi_txn_done) chk("done_lat", req0_txn_done | req1_txn_done, 1);
        if (req0_txn_done || req1_txn_done) begin
          if (sb.size() == 0) begin
            chk("done_spurious", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            chk("done_who", req1_txn_done, mon_e.who);
            chk("rx_byte", mon_e.who ? req1_data_rx : req0_data_rx, mon_e.rx);
          end
        end
        spi_txn_done = 1'b0;
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            chk("tx_hold", spi_data_tx, core_tx);
            spi_txn_done = 1'b1;
            spi_data_rx  = core_rx;
          end
        end
        if (spi_txn_start) begin
          nstart++;
          if (sb.size() == 0) chk("start_spurious", 1, 0);
          else                chk("tx_byte", spi_data_tx, sb[0].tx);
          core_cnt = CORE_LAT;
          core_tx  = spi_data_tx;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int cnt;
    rst_n = 1'b0;
    req0_lock = 1'b0; req1_lock = 1'b0;
    req0_cs_sel = CS_SEL_W'(CS_FLASH); req1_cs_sel = CS_SEL_W'(CS_EXT);
    req0_data_tx = 8'h00; req1_data_tx = 8'h00;
    req0_txn_start = 1'b0; req1_txn_start = 1'b0;
    tick(2);

    // Reset values.
    chk("rst_cs", spi_cs_n, 3'b111);
    chk("rst_g0", req0_grant, 0);
    chk("rst_g1", req1_grant, 0);
    chk("rst_start", spi_txn_start, 0);
    chk("rst_done", {req0_txn_done, req1_txn_done}, 0);
    chk("rst_tx", spi_data_tx, 8'h00);
    chk("rst_rx", {req0_data_rx, req1_data_rx}, 16'h0000);

    // Both locks from reset: req0 takes the first tie.
    req0_lock = 1'b1;
    req1_lock = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("grant_early", req0_grant | req1_grant, 0);
    tick();
    chk("tie_g0", req0_grant, 1);
    chk("tie_g1", req1_grant, 0);
    chk("tie_cs", spi_cs_n, 3'b110);

    send(1'b0, 8'hA1, 8'h3C, 1'b0);

    // Non-owner start is dropped.
    drive_start(1'b1, 1'b1, 8'hEE);
    tick();
    drive_start(1'b1, 1'b0, 8'hEE);
    tick(4);
    chk("nonowner_start", nstart, exp_starts);

    // Second start while BUSY is dropped.
    send(1'b0, 8'h12, 8'h34, 1'b1);
    tick(4);
    chk("busy_start", nstart, exp_starts);

    // Select change while owning leaves CS alone.
    req0_cs_sel = CS_SEL_W'(CS_RAM);
    tick(2);
    chk("sel_change_cs", spi_cs_n, 3'b110);

    // Release: CS high for RELEASE plus IDLE, then req1 granted.
    req0_lock = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spi_cs_n == 3'b111) cnt++;
      else if (cnt > 0) break;
    end
    chk("gap_len", cnt, IDLE_GAP + 1);
    chk("alt_g1", req1_grant, 1);
    chk("alt_g0", req0_grant, 0);
    chk("alt_cs", spi_cs_n, 3'b011);

    send(1'b1, 8'h55, 8'hC3, 1'b0);
    chk("nonowner_rx0", req0_data_rx, 8'h34);

    // Lock drop mid-byte: byte completes, CS drops a cycle after done.
    req0_cs_sel = 2'd3;
    expect_byte(1'b1, 8'h66, 8'h99);
    drive_start(1'b1, 1'b1, 8'h66);
    tick();
    drive_start(1'b1, 1'b0, 8'h66);
    req1_lock = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req1_txn_done) begin
        ok = 1'b1;
        break;
      end
      chk("drop_cs_held", spi_cs_n, 3'b011);
    end
    chk("drop_done", ok, 1);
    chk("drop_cs_at_done", spi_cs_n, 3'b011);
    req0_lock = 1'b1;
    req1_lock = 1'b1;
    tick();
    chk("drop_cs_after", spi_cs_n, 3'b111);
    chk("drop_g1", req1_grant, 0);

    // req1 owned last, so req0 wins this tie; its select is out of range.
    wait_grant("oor_wait");
    chk("oor_g0", req0_grant, 1);
    chk("oor_g1", req1_grant, 0);
    chk("oor_cs", spi_cs_n, 3'b111);
    send(1'b0, 8'h77, 8'h88, 1'b0);
    chk("nonowner_rx1", req1_data_rx, 8'h99);

    // Hand over to req1, then reset in the middle of its byte.
    req0_lock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req1_grant) break;
    end
    chk("ho_g1", req1_grant, 1);
    expect_byte(1'b1, 8'hF0, 8'h0F);
    drive_start(1'b1, 1'b1, 8'hF0);
    tick();
    drive_start(1'b1, 1'b0, 8'hF0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", spi_cs_n, 3'b111);
    chk("mid_rst_g", {req0_grant, req1_grant}, 0);
    chk("mid_rst_start", spi_txn_start, 0);
    chk("mid_rst_tx", spi_data_tx, 8'h00);
    sb.delete();
    req1_lock = 1'b0;
    req0_cs_sel = CS_SEL_W'(CS_RAM);
    tick(2);
    rst_n = 1'b1;
    req0_lock = 1'b1;
    tick(2);
    chk("fresh_g0", req0_grant, 1);
    chk("fresh_cs", spi_cs_n, 3'b101);
    chk("fresh_rx", {req0_data_rx, req1_data_rx}, 16'h0000);
    send(1'b0, 8'h03, 8'h5A, 1'b0);
    req0_lock = 1'b0;
    tick(6);

    chk("sb_empty", sb.size(), 0);
    chk("start_count", nstart, exp_starts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
